// File: rtl/serial_pkt_pkg.sv
// Shared types for the serial packet receiver: field widths,
// bit-counter width and the framing FSM states.
package serial_pkt_pkg;

  localparam int PKT_W  = 44;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PKT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/serial_packet_receiver_44b_sipo.sv
// Serial-in/parallel-out shift register, MSB arrives first.
// Ports: clk, rst (sync, active-high), en, sin -> q[W-1:0].
module serial_packet_receiver_44b_sipo
  import serial_pkt_pkg::*;
#(
  parameter int W = PKT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/serial_packet_receiver_44b.sv
// Frames a serial bit stream into 44-bit {addr,data} packets.
// Ports: clk, rst, frame/bit_val/bit_in in; pkt val/rdy/addr/data,
// busy, short_err, overrun out.
module serial_packet_receiver_44b
  import serial_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              frame,
  input  logic              bit_val,
  input  logic              bit_in,
  output logic              pkt_val,
  input  logic              pkt_rdy,
  output logic [ADDR_W-1:0] pkt_addr,
  output logic [DATA_W-1:0] pkt_data,
  output logic              busy,
  output logic              short_err,
  output logic              overrun
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PKT_W-1:0] sreg;
  logic             accept;
  logic             abort;
  logic             last;
  logic             short_q;
  logic             ovr_q;

  assign accept = frame & bit_val & (state_q != HOLD);
  // Frame dropped mid-packet: discard partial bits.
  assign abort  = (state_q == SHIFT) & ~frame;
  assign last   = accept & (cnt_q == LAST_BIT);

  serial_packet_receiver_44b_sipo #(
    .W(PKT_W)
  ) u_sipo (
    .clk(clk),
    .rst(rst | abort),
    .en (accept),
    .sin(bit_in),
    .q  (sreg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (pkt_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= abort;
      // Bits offered while a packet is held are lost.
      ovr_q   <= ovr_q | ((state_q == HOLD) & frame & bit_val);
    end
  end

  assign pkt_val   = (state_q == HOLD);
  assign busy      = (state_q == SHIFT);
  assign short_err = short_q;
  assign overrun   = ovr_q;
  assign pkt_addr  = sreg[PKT_W-1 -: ADDR_W];
  assign pkt_data  = sreg[DATA_W-1:0];

endmodule

// File: tb/tb_serial_packet_receiver_44b.sv
// Directed bench for serial_packet_receiver_44b: table of packets
// plus hand-written overrun / short / reset / back-to-back cases.
module tb_serial_packet_receiver_44b;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic        bit_val;
  logic        bit_in;
  logic        pkt_val;
  logic        pkt_rdy;
  logic [11:0] pkt_addr;
  logic [31:0] pkt_data;
  logic        busy;
  logic        short_err;
  logic        overrun;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_packet_receiver_44b dut (
    .clk      (clk),
    .rst      (rst),
    .frame    (frame),
    .bit_val  (bit_val),
    .bit_in   (bit_in),
    .pkt_val  (pkt_val),
    .pkt_rdy  (pkt_rdy),
    .pkt_addr (pkt_addr),
    .pkt_data (pkt_data),
    .busy     (busy),
    .short_err(short_err),
    .overrun  (overrun)
  );

  typedef struct {
    logic [43:0] pkt;
    bit          gap;
    logic [11:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    frame   = 1'b0;
    bit_val = 1'b0;
    bit_in  = 1'b0;
    pkt_rdy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Sends n bits of p starting at bit 43, optionally with
  // one idle cycle between bits. busy_bad flags any gap
  // cycle where busy was low.
  task automatic send(input logic [43:0] p, input int n,
                      input bit gap, output bit busy_bad);
    logic [43:0] v;
    v = p;
    busy_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      frame   = 1'b1;
      bit_val = 1'b1;
      bit_in  = v[43 - i];
      tick();
      if (i < 43 && !busy) busy_bad = 1'b1;
      if (gap && i < n - 1) begin
        bit_val = 1'b0;
        tick();
        if (!busy) busy_bad = 1'b1;
      end
    end
    bit_val = 1'b0;
  endtask

  task automatic handshake();
    frame   = 1'b0;
    bit_val = 1'b0;
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
  endtask

  bit bb;
  logic [31:0] d0;

  initial begin
    tbl[0] = '{44'h123DEADBEEF, 1'b0, 12'h123, 32'hDEADBEEF};
    tbl[1] = '{44'h123DEADBEEF, 1'b1, 12'h123, 32'hDEADBEEF};
    tbl[2] = '{44'h000FFFFFFFF, 1'b0, 12'h000, 32'hFFFFFFFF};
    tbl[3] = '{44'hFFF00000000, 1'b1, 12'hFFF, 32'h00000000};
    tbl[4] = '{44'h80000000001, 1'b0, 12'h800, 32'h00000001};

    rst = 1'b0;
    idle();
    do_reset();
    chk("rst_val",   pkt_val,   0);
    chk("rst_addr",  pkt_addr,  0);
    chk("rst_data",  pkt_data,  0);
    chk("rst_busy",  busy,      0);
    chk("rst_short", short_err, 0);
    chk("rst_ovr",   overrun,   0);

    foreach (tbl[k]) begin
      send(tbl[k].pkt, 44, tbl[k].gap, bb);
      chk($sformatf("t%0d_busy", k), bb, 0);
      chk($sformatf("t%0d_val", k), pkt_val, 1);
      chk($sformatf("t%0d_addr", k), pkt_addr, tbl[k].ea);
      chk($sformatf("t%0d_data", k), pkt_data, tbl[k].ed);
      chk($sformatf("t%0d_bsy0", k), busy, 0);
      handshake();
      chk($sformatf("t%0d_drop", k), pkt_val, 0);
      chk($sformatf("t%0d_idle", k), busy, 0);
      chk($sformatf("t%0d_ovr", k), overrun, 0);
    end

    // Backpressure with bits arriving during HOLD.
    send(44'hFFF00000001, 44, 1'b0, bb);
    bb = 1'b0;
    for (int c = 0; c < 5; c++) begin
      frame   = 1'b1;
      bit_val = (c < 3);
      bit_in  = 1'b1;
      tick();
      if (!pkt_val || pkt_addr !== 12'hFFF ||
          pkt_data !== 32'h00000001) bb = 1'b1;
    end
    chk("bp_hold", bb, 0);
    chk("bp_ovr", overrun, 1);
    handshake();
    chk("bp_drop", pkt_val, 0);
    tick();
    tick();
    chk("bp_sticky", overrun, 1);
    do_reset();
    chk("bp_clr", overrun, 0);

    // Short frame: 20 bits then frame low.
    send(44'hABCDEF12345, 20, 1'b0, bb);
    chk("sh_busy1", busy, 1);
    frame = 1'b0;
    tick();
    chk("sh_pulse", short_err, 1);
    chk("sh_busy0", busy, 0);
    chk("sh_val", pkt_val, 0);
    tick();
    chk("sh_one", short_err, 0);
    send(44'h00100000002, 44, 1'b0, bb);
    chk("sh_val2", pkt_val, 1);
    chk("sh_addr", pkt_addr, 12'h001);
    chk("sh_data", pkt_data, 32'h00000002);
    handshake();

    // Single-bit frame.
    send(44'h80000000000, 1, 1'b0, bb);
    frame = 1'b0;
    tick();
    chk("one_pulse", short_err, 1);
    tick();
    chk("one_end", short_err, 0);

    // Reset in the middle of a packet.
    send(44'hFEDCBA98765, 30, 1'b0, bb);
    frame   = 1'b1;
    bit_val = 1'b1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("mr_addr", pkt_addr, 0);
    chk("mr_data", pkt_data, 0);
    chk("mr_busy", busy, 0);
    chk("mr_val", pkt_val, 0);
    tick();
    chk("mr_short", short_err, 0);
    send(44'hABC12345678, 44, 1'b0, bb);
    chk("mr_addr2", pkt_addr, 12'hABC);
    chk("mr_data2", pkt_data, 32'h12345678);
    handshake();

    // Back-to-back, handshake in first HOLD cycle.
    send(44'h5A50F0F0F0F, 44, 1'b0, bb);
    chk("bb_val1", pkt_val, 1);
    chk("bb_addr1", pkt_addr, 12'h5A5);
    d0 = pkt_data;
    chk("bb_data1", d0, 32'h0F0F0F0F);
    frame   = 1'b1;
    pkt_rdy = 1'b1;
    tick();
    pkt_rdy = 1'b0;
    chk("bb_drop", pkt_val, 0);
    send(44'h3C3A5A5A5A5, 44, 1'b0, bb);
    chk("bb_val2", pkt_val, 1);
    chk("bb_addr2", pkt_addr, 12'h3C3);
    chk("bb_data2", pkt_data, 32'hA5A5A5A5);
    chk("bb_ovr", overrun, 0);
    handshake();
    chk("bb_end", pkt_val, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_fail);
    $finish;
  end

endmodule
